// File: rtl/sample_gen_pkg.sv
// Shared types and constants for the multi-channel DAC sample generator.
package sample_gen_pkg;

  typedef enum logic [1:0] {
    SG_OFF  = 2'd0,
    SG_DC   = 2'd1,
    SG_LFSR = 2'd2,
    SG_TRI  = 2'd3
  } sg_mode_t;

  localparam int CNT_W = 32;

  // Fibonacci feedback mask for each supported sample width.
  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      8:       return 16'h00B8;
      12:      return 16'h0E08;
      14:      return 16'h3802;
      16:      return 16'hB400;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic width_supported(input int width);
    return (width == 8) || (width == 12) || (width == 14) || (width == 16);
  endfunction

endpackage

// File: rtl/sample_gen_channel.sv
// One DAC channel: mode/arg registers, per-lane LFSRs, triangle phase
// accumulator, stallable output pipe and emitted-batch counter.
module sample_gen_channel
  import sample_gen_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BATCH_SIZE   = 16,
  parameter int PIPE_STAGES  = 5
) (
  input  logic                               clk,
  input  logic                               rst_in_n,
  input  logic                               halt,
  input  logic                               cfg_load,
  input  sg_mode_t                           cfg_mode,
  input  logic [SAMPLE_WIDTH-1:0]            cfg_arg,
  input  logic                               dac_rdy,
  output logic [BATCH_SIZE*SAMPLE_WIDTH-1:0] dac_batch,
  output logic                               dac_valid,
  output logic [CNT_W-1:0]                   batch_count
);

  localparam int W  = SAMPLE_WIDTH;
  localparam int BW = BATCH_SIZE * SAMPLE_WIDTH;
  localparam logic [W-1:0] TAP      = W'(lfsr_taps(W));
  localparam logic [W:0]   BATCH_MUL = (W+1)'(BATCH_SIZE);

  sg_mode_t         mode_q;
  logic [W-1:0]     arg_q;
  logic             load_q;
  logic [W-1:0]     lane_q [BATCH_SIZE];
  logic [W:0]       acc_q;
  logic [W-1:0]     seed   [BATCH_SIZE];
  logic             advance;
  logic             gen_valid;
  logic [BW-1:0]    gen_data;
  logic [W:0]       phase;
  logic [PIPE_STAGES-1:0] pipe_v_q;
  logic [BW-1:0]    pipe_d_q [PIPE_STAGES];
  logic [CNT_W-1:0] count_q;

  // A config landing this cycle takes priority over stepping the generator.
  assign advance = dac_rdy && (mode_q != SG_OFF) && !load_q && !cfg_load && !halt;

  // Per-lane LFSR seeds: arg + lane index, with the all-zero lock-up state avoided.
  always_comb begin
    for (int i = 0; i < BATCH_SIZE; i++) begin
      seed[i] = arg_q + W'(i);
      if (seed[i] == '0) seed[i] = W'(1);
    end
  end

  // Batch presented to the pipe this cycle; invalid batches carry zero data.
  always_comb begin
    gen_valid = (mode_q != SG_OFF) && !load_q && !halt;
    gen_data  = '0;
    phase     = '0;
    for (int i = 0; i < BATCH_SIZE; i++) begin
      phase = acc_q + (W+1)'(i) * {1'b0, arg_q};
      if (gen_valid) begin
        case (mode_q)
          SG_DC:   gen_data[i*W +: W] = arg_q;
          SG_LFSR: gen_data[i*W +: W] = lane_q[i];
          SG_TRI:  gen_data[i*W +: W] = phase[W] ? ~phase[W-1:0] : phase[W-1:0];
          default: gen_data[i*W +: W] = '0;
        endcase
      end
    end
  end

  // Mode/argument latch; load_q marks the single reload (bubble) cycle.
  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      mode_q <= SG_OFF;
      arg_q  <= '0;
      load_q <= 1'b0;
    end else if (halt) begin
      mode_q <= SG_OFF;
      load_q <= 1'b0;
    end else if (cfg_load) begin
      mode_q <= cfg_mode;
      arg_q  <= cfg_arg;
      load_q <= 1'b1;
    end else begin
      load_q <= 1'b0;
    end
  end

  // Generator state: cleared by halt, reloaded in the load cycle, stepped on advance.
  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      for (int i = 0; i < BATCH_SIZE; i++) lane_q[i] <= '0;
      acc_q <= '0;
    end else if (halt) begin
      for (int i = 0; i < BATCH_SIZE; i++) lane_q[i] <= '0;
      acc_q <= '0;
    end else if (load_q) begin
      for (int i = 0; i < BATCH_SIZE; i++) lane_q[i] <= seed[i];
      acc_q <= '0;
    end else if (advance) begin
      for (int i = 0; i < BATCH_SIZE; i++)
        lane_q[i] <= {lane_q[i][W-2:0], ^(lane_q[i] & TAP)};
      acc_q <= acc_q + BATCH_MUL * {1'b0, arg_q};
    end
  end

  // Output pipe shifts only while downstream is ready.
  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      pipe_v_q <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) pipe_d_q[k] <= '0;
    end else if (dac_rdy) begin
      for (int k = PIPE_STAGES - 1; k > 0; k--) begin
        pipe_v_q[k] <= pipe_v_q[k-1];
        pipe_d_q[k] <= pipe_d_q[k-1];
      end
      pipe_v_q[0] <= gen_valid;
      pipe_d_q[0] <= gen_data;
    end
  end

  // Count every batch actually handed downstream; wraps naturally.
  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) count_q <= '0;
    else if (dac_valid) count_q <= count_q + 1'b1;
  end

  assign dac_valid   = dac_rdy & pipe_v_q[PIPE_STAGES-1];
  assign dac_batch   = dac_rdy ? pipe_d_q[PIPE_STAGES-1] : '0;
  assign batch_count = count_q;

endmodule

// File: rtl/mc_sample_generator.sv
// Multi-channel DAC test-pattern generator: decodes the config port,
// fans out halt and concatenates per-channel outputs.
module mc_sample_generator
  import sample_gen_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int SAMPLE_WIDTH = 16,
  parameter int BATCH_SIZE   = 16,
  parameter int PIPE_STAGES  = 5
) (
  input  logic                                      clk,
  input  logic                                      rst_in_n,
  input  logic                                      halt,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [1:0]                                cfg_mode,
  input  logic [SAMPLE_WIDTH-1:0]                   cfg_arg,
  input  logic                                      cfg_valid,
  output logic                                      cfg_rdy,
  input  logic [NUM_CH-1:0]                         dac_rdy,
  output logic [NUM_CH*BATCH_SIZE*SAMPLE_WIDTH-1:0] dac_batch,
  output logic [NUM_CH-1:0]                         dac_valid,
  output logic [NUM_CH*CNT_W-1:0]                   batch_count
);

  localparam int BW = BATCH_SIZE * SAMPLE_WIDTH;

  if (!width_supported(SAMPLE_WIDTH)) begin : g_bad_width
    $error("mc_sample_generator: SAMPLE_WIDTH must be 8, 12, 14 or 16");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("mc_sample_generator: NUM_CH must be 1..8");
  end
  if (PIPE_STAGES < 1) begin : g_bad_pipe
    $error("mc_sample_generator: PIPE_STAGES must be at least 1");
  end

  logic              cfg_fire;
  logic [NUM_CH-1:0] cfg_load;

  // Ready reads the reset pin directly so it is low throughout reset.
  assign cfg_rdy  = rst_in_n & ~halt;
  assign cfg_fire = cfg_valid & cfg_rdy;

  // Channel select; out-of-range channel numbers match nothing and are dropped.
  always_comb begin
    cfg_load = '0;
    for (int c = 0; c < NUM_CH; c++)
      cfg_load[c] = cfg_fire && (int'(cfg_ch) == c);
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sample_gen_channel #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .BATCH_SIZE   (BATCH_SIZE),
      .PIPE_STAGES  (PIPE_STAGES)
    ) u_channel (
      .clk         (clk),
      .rst_in_n    (rst_in_n),
      .halt        (halt),
      .cfg_load    (cfg_load[c]),
      .cfg_mode    (sg_mode_t'(cfg_mode)),
      .cfg_arg     (cfg_arg),
      .dac_rdy     (dac_rdy[c]),
      .dac_batch   (dac_batch[c*BW +: BW]),
      .dac_valid   (dac_valid[c]),
      .batch_count (batch_count[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_mc_sample_generator.sv
// Directed bench for mc_sample_generator: vector table plus corner sequences.
module tb_mc_sample_generator;

  localparam int NUM_CH = 2;
  localparam int W      = 16;
  localparam int B      = 16;
  localparam int P      = 5;
  localparam int BW     = B * W;

  logic                   clk = 1'b0;
  logic                   rst_in_n;
  logic                   halt;
  logic [0:0]             cfg_ch;
  logic [1:0]             cfg_mode;
  logic [W-1:0]           cfg_arg;
  logic                   cfg_valid;
  logic                   cfg_rdy;
  logic [NUM_CH-1:0]      dac_rdy;
  logic [NUM_CH*BW-1:0]   dac_batch;
  logic [NUM_CH-1:0]      dac_valid;
  logic [NUM_CH*32-1:0]   batch_count;

  int n_checks = 0;
  int n_fail   = 0;

  mc_sample_generator #(
    .NUM_CH(NUM_CH), .SAMPLE_WIDTH(W), .BATCH_SIZE(B), .PIPE_STAGES(P)
  ) dut (
    .clk(clk), .rst_in_n(rst_in_n), .halt(halt),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_arg(cfg_arg),
    .cfg_valid(cfg_valid), .cfg_rdy(cfg_rdy),
    .dac_rdy(dac_rdy), .dac_batch(dac_batch), .dac_valid(dac_valid),
    .batch_count(batch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           ch;
    logic [1:0]   mode;
    logic [W-1:0] arg;
    logic         vld;
    logic [W-1:0] l0, l1, l15;   // first batch lanes 0, 1, 15
    logic [W-1:0] n0;            // second batch lane 0
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [W-1:0] smp(input int ch, input int i);
    return dac_batch[ch*BW + i*W +: W];
  endfunction

  function automatic logic [BW-1:0] chb(input int ch);
    return dac_batch[ch*BW +: BW];
  endfunction

  function automatic logic [31:0] cnt(input int ch);
    return batch_count[ch*32 +: 32];
  endfunction

  function automatic logic [W-1:0] lfsr_nx(input logic [W-1:0] s);
    return {s[W-2:0], ^(s & 16'hB400)};
  endfunction

  function automatic logic [BW-1:0] tri_batch(input logic [W:0] acc, input logic [W-1:0] arg);
    logic [BW-1:0] r;
    logic [W:0]    p;
    r = '0;
    for (int i = 0; i < B; i++) begin
      p = acc + (W+1)'(i) * {1'b0, arg};
      r[i*W +: W] = p[W] ? ~p[W-1:0] : p[W-1:0];
    end
    return r;
  endfunction

  // Hold halt long enough to drain every pipe, then release it.
  task automatic flush();
    halt      = 1'b1;
    cfg_valid = 1'b0;
    repeat (P + 2) step();
    halt = 1'b0;
  endtask

  // Present one command in the current cycle; returns in the load cycle.
  task automatic cfg(input int ch, input logic [1:0] m, input logic [W-1:0] a);
    cfg_ch    = 1'(ch);
    cfg_mode  = m;
    cfg_arg   = a;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  ml [B];
    logic [W:0]    macc;
    logic [W-1:0]  marg;
    logic [W:0]    tacc;
    logic [BW-1:0] exp_b;
    logic [63:0]   hc;
    int            nb0, nb1, nb;
    bit            st0, st1;
    logic [31:0]   c_first;

    vecs[0] = '{0, 2'd1, 16'h1234, 1'b1, 16'h1234, 16'h1234, 16'h1234, 16'h1234};
    vecs[1] = '{1, 2'd3, 16'h1000, 1'b1, 16'h0000, 16'h1000, 16'hF000, 16'hFFFF};
    vecs[2] = '{0, 2'd2, 16'h0000, 1'b1, 16'h0001, 16'h0001, 16'h000F, 16'h0002};
    vecs[3] = '{1, 2'd2, 16'hFFFF, 1'b1, 16'hFFFF, 16'h0001, 16'h000E, 16'hFFFE};
    vecs[4] = '{0, 2'd3, 16'h0800, 1'b1, 16'h0000, 16'h0800, 16'h7800, 16'h8000};
    vecs[5] = '{0, 2'd3, 16'h3000, 1'b1, 16'h0000, 16'h3000, 16'hD000, 16'hFFFF};
    vecs[6] = '{0, 2'd0, 16'h1234, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[7] = '{1, 2'd1, 16'hA5A5, 1'b1, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};
    vecs[8] = '{0, 2'd2, 16'h8000, 1'b1, 16'h8000, 16'h8001, 16'h800F, 16'h0001};

    rst_in_n  = 1'b0;
    halt      = 1'b0;
    cfg_ch    = '0;
    cfg_mode  = '0;
    cfg_arg   = '0;
    cfg_valid = 1'b0;
    dac_rdy   = 2'b11;

    // Reset state
    repeat (2) step();
    settle();
    chk("rst_cfg_rdy", cfg_rdy, 1'b0);
    chk("rst_valid", dac_valid, 2'b00);
    chk("rst_batch0", chb(0), '0);
    chk("rst_batch1", chb(1), '0);
    chk("rst_count", batch_count, '0);
    rst_in_n = 1'b1;

    // Idle after reset, no config
    for (int k = 0; k < 100; k++) begin
      step();
      settle();
      chk("idle_cfg_rdy", cfg_rdy, 1'b1);
      chk("idle_valid", dac_valid, 2'b00);
      chk("idle_batch", {255'd0, |dac_batch}, '0);
      chk("idle_count", batch_count, '0);
    end

    // Vector table: latency, first/second batch, count delta
    for (int v = 0; v < 9; v++) begin
      flush();
      cfg(vecs[v].ch, vecs[v].mode, vecs[v].arg);
      repeat (P) step();
      settle();
      chk("vec_bubble", dac_valid[vecs[v].ch], 1'b0);
      step();
      settle();
      c_first = cnt(vecs[v].ch);
      chk("vec_valid", dac_valid[vecs[v].ch], vecs[v].vld);
      chk("vec_l0", smp(vecs[v].ch, 0), vecs[v].l0);
      chk("vec_l1", smp(vecs[v].ch, 1), vecs[v].l1);
      chk("vec_l15", smp(vecs[v].ch, 15), vecs[v].l15);
      chk("vec_other_idle", dac_valid[1 - vecs[v].ch], 1'b0);
      step();
      settle();
      chk("vec_n0", smp(vecs[v].ch, 0), vecs[v].n0);
      chk("vec_count", cnt(vecs[v].ch) - c_first, 32'(vecs[v].vld));
    end

    // Long run: ch0 LFSR seed 0, ch1 TRI 0x1000, 1000 batches each
    flush();
    cfg(0, 2'd2, 16'h0000);
    cfg(1, 2'd3, 16'h1000);
    for (int i = 0; i < B; i++) begin
      ml[i] = 16'(i);
      if (ml[i] == '0) ml[i] = 16'h0001;
    end
    macc = '0;
    marg = 16'h1000;
    nb0 = 0; nb1 = 0; st0 = 0; st1 = 0;
    for (int k = 0; k < 1300 && (nb0 < 1000 || nb1 < 1000); k++) begin
      step();
      settle();
      if (nb0 < 1000) begin
        if (dac_valid[0]) st0 = 1;
        if (st0) begin
          for (int i = 0; i < B; i++) exp_b[i*W +: W] = ml[i];
          chk("lfsr_valid", dac_valid[0], 1'b1);
          chk("lfsr_batch", chb(0), exp_b);
          for (int i = 0; i < B; i++) ml[i] = lfsr_nx(ml[i]);
          nb0++;
        end
      end
      if (nb1 < 1000) begin
        if (dac_valid[1]) st1 = 1;
        if (st1) begin
          chk("tri_valid", dac_valid[1], 1'b1);
          chk("tri_batch", chb(1), tri_batch(macc, marg));
          macc = macc + (W+1)'(B) * {1'b0, marg};
          nb1++;
        end
      end
    end
    chk("lfsr_batches", nb0, 1000);
    chk("tri_batches", nb1, 1000);

    // Random stall on ch0 (TRI 0x0700) while ch1 runs DC 0x5555
    flush();
    cfg(0, 2'd3, 16'h0700);
    cfg(1, 2'd1, 16'h5555);
    c_first = cnt(0);
    tacc = '0;
    nb = 0;
    st1 = 0;
    for (int k = 0; k < 600; k++) begin
      step();
      dac_rdy[0] = 1'($urandom_range(0, 1));
      dac_rdy[1] = 1'b1;
      settle();
      if (!dac_rdy[0]) begin
        chk("stall_quiet", {255'd0, (dac_valid[0] || chb(0) != '0)}, '0);
      end else if (dac_valid[0]) begin
        chk("stall_batch", chb(0), tri_batch(tacc, 16'h0700));
        tacc = tacc + (W+1)'(B) * 17'h00700;
        nb++;
      end
      if (dac_valid[1]) st1 = 1;
      if (st1) begin
        chk("ch1_valid", dac_valid[1], 1'b1);
        chk("ch1_batch", chb(1), {B{16'h5555}});
      end
    end
    step();
    chk("stall_count", cnt(0) - c_first, 32'(nb));
    chk("stall_enough", {255'd0, nb > 100}, 1);
    dac_rdy = 2'b11;

    // Halt mid-stream with a pending config
    repeat (P + 3) step();
    halt      = 1'b1;
    cfg_ch    = 1'b0;
    cfg_mode  = 2'd1;
    cfg_arg   = 16'h7777;
    cfg_valid = 1'b1;
    settle();
    chk("halt_cfg_rdy", cfg_rdy, 1'b0);
    chk("halt_still_valid", dac_valid, 2'b11);
    repeat (P - 1) step();
    settle();
    chk("halt_drain", dac_valid, 2'b11);
    step();
    settle();
    chk("halt_flushed", dac_valid, 2'b00);
    hc = batch_count;
    repeat (5) step();
    settle();
    chk("halt_count_held", batch_count, hc);
    step();
    halt      = 1'b0;
    cfg_valid = 1'b0;
    repeat (P + 4) step();
    settle();
    chk("post_halt_idle", dac_valid, 2'b00);

    // Reconfig mid-stream: old data drains, one bubble, then new data
    cfg(0, 2'd1, 16'h1111);
    repeat (P + 3) step();
    cfg(0, 2'd1, 16'h2222);
    repeat (P - 1) step();
    settle();
    chk("reconf_old_valid", dac_valid[0], 1'b1);
    chk("reconf_old_data", smp(0, 0), 16'h1111);
    step();
    settle();
    chk("reconf_bubble", dac_valid[0], 1'b0);
    step();
    settle();
    chk("reconf_new_valid", dac_valid[0], 1'b1);
    chk("reconf_new_data", chb(0), {B{16'h2222}});

    // Asynchronous reset mid-stream
    step();
    #2;
    rst_in_n = 1'b0;
    #1;
    chk("arst_valid", dac_valid, 2'b00);
    chk("arst_batch0", chb(0), '0);
    chk("arst_batch1", chb(1), '0);
    chk("arst_count", batch_count, '0);
    chk("arst_cfg_rdy", cfg_rdy, 1'b0);
    step();
    step();
    rst_in_n = 1'b1;
    repeat (P + 3) step();
    settle();
    chk("post_rst_idle", dac_valid, 2'b00);
    chk("post_rst_cfg_rdy", cfg_rdy, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
